uart_dec_framer: RTL and testbench

Upstream stage of the UART transmit path: on a start strobe it snapshots a 32-bit unsigned value, converts it to ASCII decimal with a sequential double-dabble, and streams the characters followed by CR LF as bytes over a valid/ready handshake. The consumer is the UART byte transmitter that drives `o_uart_tx`. It is used to stream controller telemetry (velocity, PID output) to a host terminal.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/bin2bcd_seq.sv | 84 ++++++++
 rtl/uart_dec_framer.sv | 150 +++++++++++++++
 tb/tb_uart_dec_framer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit path: default value width and BCD
// digit count (also used by the UART byte transmitter), the ASCII characters
// the decimal framer emits, and the framer state encoding.
// No ports: package only.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NUM_DIGITS = 10;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SEND_DIGIT,
        ST_SEND_CR,
        ST_SEND_LF
    } framer_state_e;

    // Map one BCD digit to its ASCII character.
    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one adjust+shift step per clock, so a
// conversion takes DATA_W cycles after the start cycle. The result stays on
// bcd_o until the next start, which lets a consumer read digits at leisure.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous active-high reset
//   start_i  in   load bin_i and begin a conversion (ignored while busy)
//   bin_i    in   DATA_W-bit unsigned value
//   busy_o   out  conversion in progress
//   done_o   out  one-cycle pulse once bcd_o holds the final result
//   bcd_o    out  NUM_DIGITS packed BCD digits, digit 0 in the low nibble
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;

    // Any digit >= 5 would overflow past 9 when doubled; pre-adding 3 makes
    // the shift carry into the next digit instead.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                bin_q  <= bin_i;
                bcd_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                // Shift the adjusted BCD and the binary together so the binary
                // MSB lands in digit 0's LSB.
                {bcd_q, bin_q} <= {dabble_adjust(bcd_q), bin_q} << 1;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/uart_dec_framer.sv
// ---------------------------------------------------------------------------
// uart_dec_framer
// Snapshots an unsigned value on an accepted start, converts it to decimal
// and streams the digits (leading zeros suppressed) followed by CR LF as
// ASCII bytes over a valid/ready handshake towards the UART byte transmitter.
// Ports:
//   Clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   i_data        in   value to print, sampled only on an accepted start
//   i_start       in   one-cycle request, accepted only while o_busy is low
//   o_busy        out  high from the cycle after acceptance until LF transfers
//   o_byte        out  ASCII character
//   o_byte_valid  out  o_byte is valid; registered, independent of ready
//   i_byte_ready  in   sink accepts the byte (transfer = valid & ready)
// ---------------------------------------------------------------------------
module uart_dec_framer
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_start,
    output logic              o_busy,
    output logic [7:0]        o_byte,
    output logic              o_byte_valid,
    input  logic              i_byte_ready
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS + 1);

    framer_state_e     state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        byte_q;
    logic              valid_q;
    logic              busy_q;

    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic [IDX_W-1:0]  first_idx_d;
    logic              xfer;

    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b,
                                            input logic [IDX_W-1:0] idx);
        logic [3:0] d;
        d = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                d = b[4*i +: 4];
            end
        end
        return d;
    endfunction

    // Highest nonzero digit; falls back to digit 0 so a zero value prints "0".
    function automatic logic [IDX_W-1:0] msd_index(input logic [BCD_W-1:0] b);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] != 4'h0) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    assign conv_start  = (state_q == ST_IDLE) && i_start && !conv_busy;
    assign first_idx_d = msd_index(conv_bcd);
    assign xfer        = valid_q && i_byte_ready;

    // The converter keeps its result after done, so digits are read straight
    // from it while sending instead of being copied into a second register.
    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk_i   (Clk),
        .rst_i   (rst),
        .start_i (conv_start),
        .bin_i   (i_data),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (conv_start) begin
                        state_q <= ST_CONVERT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (conv_done) begin
                        idx_q   <= first_idx_d;
                        byte_q  <= ascii_digit(digit_at(conv_bcd, first_idx_d));
                        valid_q <= 1'b1;
                        state_q <= ST_SEND_DIGIT;
                    end
                end
                ST_SEND_DIGIT: begin
                    if (xfer) begin
                        if (idx_q == '0) begin
                            byte_q  <= ASCII_CR;
                            state_q <= ST_SEND_CR;
                        end else begin
                            idx_q  <= idx_q - IDX_W'(1);
                            byte_q <= ascii_digit(digit_at(conv_bcd, idx_q - IDX_W'(1)));
                        end
                    end
                end
                ST_SEND_CR: begin
                    if (xfer) begin
                        byte_q  <= ASCII_LF;
                        state_q <= ST_SEND_LF;
                    end
                end
                ST_SEND_LF: begin
                    if (xfer) begin
                        byte_q  <= 8'h00;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_byte       = byte_q;
    assign o_byte_valid = valid_q;

endmodule

// File: tb/tb_uart_dec_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_dec_framer
// Bench for uart_dec_framer. Expected frames are built from the value with a
// divide-by-ten model and queued when a request is issued; a negedge monitor
// pops and compares every transferred byte and checks that a stalled byte
// holds. Each scenario task does its own timing/status checks.
// ---------------------------------------------------------------------------
module tb_uart_dec_framer;

    logic        Clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_data = 32'h0;
    logic        i_start = 1'b0;
    logic        i_byte_ready = 1'b0;
    logic        o_busy;
    logic [7:0]  o_byte;
    logic        o_byte_valid;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sbq[$];

    uart_dec_framer #(
        .DATA_W     (32),
        .NUM_DIGITS (10)
    ) dut (
        .Clk          (Clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready)
    );

    always #5 Clk = ~Clk;

    // Scoreboard monitor: samples on the falling edge, i.e. what the next
    // rising edge will see.
    initial begin : monitor
        logic       stalled;
        logic [7:0] held;
        logic [7:0] exp;
        stalled = 1'b0;
        held    = 8'h00;
        forever begin
            @(negedge Clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    vectors++;
                    if (o_byte_valid !== 1'b1 || o_byte !== held) begin
                        miscompares++;
                        $display("FAIL stall_hold: got valid=%b byte=%h, required valid=1 byte=%h",
                                 o_byte_valid, o_byte, held);
                    end
                end
                if (o_byte_valid === 1'b1 && i_byte_ready === 1'b1) begin
                    vectors++;
                    if (sbq.size() == 0) begin
                        miscompares++;
                        $display("FAIL extra_byte: got %h, required no transfer", o_byte);
                    end else begin
                        exp = sbq.pop_front();
                        if (o_byte !== exp) begin
                            miscompares++;
                            $display("FAIL byte: got %h, required %h", o_byte, exp);
                        end
                    end
                end
                stalled = (o_byte_valid === 1'b1) && (i_byte_ready !== 1'b1);
                held    = o_byte;
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] v);
        logic [7:0]  d[$];
        logic [31:0] t;
        t = v;
        do begin
            d.push_front(8'h30 + 8'(t % 10));
            t = t / 10;
        end while (t != 0);
        foreach (d[i]) sbq.push_back(d[i]);
        sbq.push_back(8'h0D);
        sbq.push_back(8'h0A);
    endtask

    task automatic start_frame(input logic [31:0] v);
        i_data  = v;
        i_start = 1'b1;
        push_frame(v);
        tick;
        i_start = 1'b0;
        i_data  = $urandom;
    endtask

    task automatic wait_frame(input int budget, input bit rnd);
        int n;
        n = 0;
        while ((sbq.size() != 0 || o_busy === 1'b1) && n < budget) begin
            if (rnd) i_byte_ready = 1'($urandom_range(0, 1));
            tick;
            n++;
        end
        i_byte_ready = 1'b1;
        vectors++;
        if (sbq.size() != 0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done: got %0d bytes outstanding busy=%b after %0d cycles, required 0 and busy=0",
                     sbq.size(), o_busy, n);
            sbq.delete();
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (o_byte_valid !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        vectors++;
        if (o_byte_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got no valid byte within %0d cycles, required valid", tag, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_byte_ready = 1'b1;
        repeat (3) tick;
        vectors += 3;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, required 0", o_busy);
        end
        if (o_byte_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b, required 0", o_byte_valid);
        end
        if (o_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_byte: got %h, required 00", o_byte);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int lat;
        int k;
        i_byte_ready = 1'b1;
        start_frame(32'd123455);
        vectors++;
        if (o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept: got %b, required 1", o_busy);
        end
        lat = 0;
        while (o_byte_valid !== 1'b1 && lat < 100) begin
            tick;
            lat++;
        end
        vectors++;
        if (lat != 33) begin
            miscompares++;
            $display("FAIL first_valid_latency: got %0d cycles, required 33", lat);
        end
        k = 0;
        while (o_busy === 1'b1 && k < 50) begin
            tick;
            k++;
        end
        vectors++;
        if (k != 8) begin
            miscompares++;
            $display("FAIL busy_drop_cycles: got %0d, required 8 (one byte per cycle, busy low after LF)", k);
        end
        vectors++;
        if (sbq.size() != 0 || o_byte_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_end: got %0d outstanding valid=%b, required 0 and valid=0",
                     sbq.size(), o_byte_valid);
            sbq.delete();
        end
    endtask

    task automatic test_zero;
        start_frame(32'd0);
        wait_frame(200, 1'b0);
    endtask

    task automatic test_max;
        start_frame(32'hFFFF_FFFF);
        wait_frame(200, 1'b0);
    endtask

    task automatic test_stall;
        start_frame(32'd1000000);
        wait_frame(2000, 1'b1);
    endtask

    task automatic test_ignore_start;
        int n;
        int busy_cycles;
        i_byte_ready = 1'b1;
        start_frame(32'd123455);
        wait_valid("ignore_first_valid");
        tick;
        i_data  = 32'd555;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        i_data  = 32'd0;
        n = 0;
        while (!(o_byte_valid === 1'b1 && o_byte === 8'h0A) && n < 100) begin
            tick;
            n++;
        end
        vectors++;
        if (!(o_byte_valid === 1'b1 && o_byte === 8'h0A)) begin
            miscompares++;
            $display("FAIL lf_reach: got valid=%b byte=%h, required valid=1 byte=0a", o_byte_valid, o_byte);
        end
        // Start coincident with the LF transfer must be dropped.
        i_data  = 32'd7;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_lf: got %b, required 0", o_busy);
        end
        busy_cycles = 0;
        repeat (40) begin
            tick;
            if (o_busy !== 1'b0 || o_byte_valid !== 1'b0) busy_cycles++;
        end
        vectors++;
        if (busy_cycles != 0 || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL ignored_start: got %0d active cycles %0d outstanding, required 0 and 0",
                     busy_cycles, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset_midframe;
        i_byte_ready = 1'b1;
        start_frame(32'd123455);
        wait_valid("midframe_first_valid");
        tick;
        i_byte_ready = 1'b0;
        rst = 1'b1;
        tick;
        vectors += 3;
        if (o_byte_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_valid: got %b, required 0", o_byte_valid);
        end
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_busy: got %b, required 0", o_busy);
        end
        if (o_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_byte: got %h, required 00", o_byte);
        end
        rst = 1'b0;
        sbq.delete();
        i_byte_ready = 1'b1;
        tick;
        start_frame(32'd90210);
        wait_frame(200, 1'b0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_max;
        test_stall;
        test_ignore_start;
        test_reset_midframe;
        repeat (3) tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
